// File: rtl/ysyx_23060077_axi_define.sv
// Shared AXI field widths, response codes and FSM state encodings
// for the AXI4 SRAM slave and its storage array.
package ysyx_23060077_axi_define;

    localparam int AXI_ADDR_W  = 32;
    localparam int AXI_DATA_W  = 64;
    localparam int AXI_STRB_W  = 8;
    localparam int AXI_ID_W    = 4;
    localparam int AXI_LEN_W   = 8;
    localparam int AXI_SIZE_W  = 3;
    localparam int AXI_BURST_W = 2;
    localparam int AXI_RESP_W  = 2;

    localparam logic [AXI_RESP_W-1:0] RESP_OKAY   = 2'b00;
    localparam logic [AXI_RESP_W-1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
    typedef enum logic [1:0] {R_IDLE, R_WAIT, R_DATA} r_state_e;

    // Every burst is handled as INCR: the address steps by the beat size.
    function automatic logic [AXI_ADDR_W-1:0] next_beat_addr(
        input logic [AXI_ADDR_W-1:0] addr,
        input logic [AXI_SIZE_W-1:0] size
    );
        return addr + (32'd1 << size);
    endfunction

endpackage

// File: rtl/ysyx_23060077_sram_mem.sv
// 64-bit wide storage array: one byte-strobed synchronous write port and
// one combinational read port (a read in the write cycle sees the old word).
module ysyx_23060077_sram_mem
    import ysyx_23060077_axi_define::*;
#(
    parameter int IDX_W = 10
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [IDX_W-1:0]      wr_idx,
    input  logic [AXI_DATA_W-1:0] wr_data,
    input  logic [AXI_STRB_W-1:0] wr_strb,
    input  logic [IDX_W-1:0]      rd_idx,
    output logic [AXI_DATA_W-1:0] rd_data
);

    logic [AXI_DATA_W-1:0] mem_q [2**IDX_W];

    // NOTE: the array has no reset on purpose; clearing it would prevent RAM
    // inference, and its contents must survive an interface reset anyway.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int b = 0; b < AXI_STRB_W; b++) begin
                if (wr_strb[b]) begin
                    mem_q[wr_idx][b*8 +: 8] <= wr_data[b*8 +: 8];
                end
            end
        end
    end

    assign rd_data = mem_q[rd_idx];

endmodule

// File: rtl/ysyx_23060077_axi_sram.sv
// AXI4 slave in front of a 64-bit SRAM: independent write (AW/W/B) and
// read (AR/R) FSMs, INCR-only bursts, SLVERR for addresses off the array.
module ysyx_23060077_axi_sram
    import ysyx_23060077_axi_define::*;
#(
    parameter logic [31:0] BASE_ADDR  = 32'h8000_0000,
    parameter int          DEPTH_LOG2 = 10,
    parameter int          RD_LAT     = 2
) (
    input  logic                   aclk,
    input  logic                   areset_n,
    input  logic                   axi_aw_valid_i,
    output logic                   axi_aw_ready_o,
    input  logic [AXI_ADDR_W-1:0]  axi_aw_addr_i,
    input  logic [AXI_ID_W-1:0]    axi_aw_id_i,
    input  logic [AXI_LEN_W-1:0]   axi_aw_len_i,
    input  logic [AXI_SIZE_W-1:0]  axi_aw_size_i,
    input  logic [AXI_BURST_W-1:0] axi_aw_burst_i,
    input  logic                   axi_w_valid_i,
    output logic                   axi_w_ready_o,
    input  logic [AXI_DATA_W-1:0]  axi_w_data_i,
    input  logic [AXI_STRB_W-1:0]  axi_w_strb_i,
    input  logic                   axi_w_last_i,
    output logic                   axi_b_valid_o,
    input  logic                   axi_b_ready_i,
    output logic [AXI_RESP_W-1:0]  axi_b_resp_o,
    output logic [AXI_ID_W-1:0]    axi_b_id_o,
    input  logic                   axi_ar_valid_i,
    output logic                   axi_ar_ready_o,
    input  logic [AXI_ADDR_W-1:0]  axi_ar_addr_i,
    input  logic [AXI_ID_W-1:0]    axi_ar_id_i,
    input  logic [AXI_LEN_W-1:0]   axi_ar_len_i,
    input  logic [AXI_SIZE_W-1:0]  axi_ar_size_i,
    input  logic [AXI_BURST_W-1:0] axi_ar_burst_i,
    output logic                   axi_r_valid_o,
    input  logic                   axi_r_ready_i,
    output logic [AXI_DATA_W-1:0]  axi_r_data_o,
    output logic [AXI_RESP_W-1:0]  axi_r_resp_o,
    output logic                   axi_r_last_o,
    output logic [AXI_ID_W-1:0]    axi_r_id_o
);

    localparam logic [AXI_ADDR_W:0] MEM_BYTES = 33'(8) << DEPTH_LOG2;

    function automatic logic addr_ok(input logic [AXI_ADDR_W-1:0] a);
        return {1'b0, a - BASE_ADDR} < MEM_BYTES;
    endfunction

    function automatic logic [DEPTH_LOG2-1:0] word_idx(input logic [AXI_ADDR_W-1:0] a);
        return DEPTH_LOG2'((a - BASE_ADDR) >> 3);
    endfunction

    w_state_e              w_state_q, w_state_d;
    logic [AXI_ADDR_W-1:0] w_addr_q, w_addr_d;
    logic [AXI_ID_W-1:0]   w_id_q, w_id_d;
    logic [AXI_LEN_W-1:0]  w_len_q, w_len_d, w_cnt_q, w_cnt_d;
    logic [AXI_SIZE_W-1:0] w_size_q, w_size_d;
    logic                  w_err_q, w_err_d;
    logic                  mem_wr_en;

    r_state_e              r_state_q, r_state_d;
    logic [AXI_ADDR_W-1:0] r_addr_q, r_addr_d;
    logic [AXI_ID_W-1:0]   r_id_q, r_id_d;
    logic [AXI_LEN_W-1:0]  r_len_q, r_len_d, r_cnt_q, r_cnt_d;
    logic [AXI_SIZE_W-1:0] r_size_q, r_size_d;
    logic [3:0]            r_wait_q, r_wait_d;
    logic [AXI_DATA_W-1:0] r_data_q, r_data_d;
    logic                  r_err_q, r_err_d;

    logic [AXI_ADDR_W-1:0] rd_addr;
    logic [AXI_DATA_W-1:0] mem_rd_data;
    logic                  rd_ok;
    logic                  unused;

    assign unused = ^{axi_w_last_i, axi_aw_burst_i, axi_ar_burst_i};

    // NOTE: every always_comb output gets its default first, so no path
    // through the case statement can leave a latch behind.
    always_comb begin
        w_state_d = w_state_q;
        w_addr_d  = w_addr_q;
        w_id_d    = w_id_q;
        w_len_d   = w_len_q;
        w_size_d  = w_size_q;
        w_cnt_d   = w_cnt_q;
        w_err_d   = w_err_q;
        mem_wr_en = 1'b0;
        case (w_state_q)
            W_IDLE: if (axi_aw_valid_i) begin
                w_addr_d  = axi_aw_addr_i;
                w_id_d    = axi_aw_id_i;
                w_len_d   = axi_aw_len_i;
                w_size_d  = axi_aw_size_i;
                w_cnt_d   = '0;
                w_err_d   = 1'b0;
                w_state_d = W_DATA;
            end
            W_DATA: if (axi_w_valid_i) begin
                mem_wr_en = addr_ok(w_addr_q);
                w_err_d   = w_err_q | ~addr_ok(w_addr_q);
                w_addr_d  = next_beat_addr(w_addr_q, w_size_q);
                w_cnt_d   = w_cnt_q + 8'd1;
                if (w_cnt_q == w_len_q) w_state_d = W_RESP;
            end
            W_RESP: if (axi_b_ready_i) w_state_d = W_IDLE;
            default: w_state_d = W_IDLE;
        endcase
    end

    // R_DATA pre-fetches the next beat's word so a handshake can reload at once.
    assign rd_addr = (r_state_q == R_DATA) ? next_beat_addr(r_addr_q, r_size_q) : r_addr_q;
    assign rd_ok   = addr_ok(rd_addr);

    always_comb begin
        r_state_d = r_state_q;
        r_addr_d  = r_addr_q;
        r_id_d    = r_id_q;
        r_len_d   = r_len_q;
        r_size_d  = r_size_q;
        r_cnt_d   = r_cnt_q;
        r_wait_d  = r_wait_q;
        r_data_d  = r_data_q;
        r_err_d   = r_err_q;
        case (r_state_q)
            R_IDLE: if (axi_ar_valid_i) begin
                r_addr_d  = axi_ar_addr_i;
                r_id_d    = axi_ar_id_i;
                r_len_d   = axi_ar_len_i;
                r_size_d  = axi_ar_size_i;
                r_cnt_d   = '0;
                r_wait_d  = 4'(RD_LAT - 1);
                r_state_d = R_WAIT;
            end
            R_WAIT: if (r_wait_q == 4'd0) begin
                r_data_d  = rd_ok ? mem_rd_data : '0;
                r_err_d   = ~rd_ok;
                r_state_d = R_DATA;
            end else begin
                r_wait_d = r_wait_q - 4'd1;
            end
            R_DATA: if (axi_r_ready_i) begin
                if (r_cnt_q == r_len_q) begin
                    r_state_d = R_IDLE;
                end else begin
                    r_addr_d = rd_addr;
                    r_cnt_d  = r_cnt_q + 8'd1;
                    r_data_d = rd_ok ? mem_rd_data : '0;
                    r_err_d  = ~rd_ok;
                end
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    always_ff @(posedge aclk or negedge areset_n) begin
        if (!areset_n) begin
            w_state_q <= W_IDLE;
            w_addr_q  <= '0;
            w_id_q    <= '0;
            w_len_q   <= '0;
            w_size_q  <= '0;
            w_cnt_q   <= '0;
            w_err_q   <= 1'b0;
            r_state_q <= R_IDLE;
            r_addr_q  <= '0;
            r_id_q    <= '0;
            r_len_q   <= '0;
            r_size_q  <= '0;
            r_cnt_q   <= '0;
            r_wait_q  <= '0;
            r_data_q  <= '0;
            r_err_q   <= 1'b0;
        end else begin
            w_state_q <= w_state_d;
            w_addr_q  <= w_addr_d;
            w_id_q    <= w_id_d;
            w_len_q   <= w_len_d;
            w_size_q  <= w_size_d;
            w_cnt_q   <= w_cnt_d;
            w_err_q   <= w_err_d;
            r_state_q <= r_state_d;
            r_addr_q  <= r_addr_d;
            r_id_q    <= r_id_d;
            r_len_q   <= r_len_d;
            r_size_q  <= r_size_d;
            r_cnt_q   <= r_cnt_d;
            r_wait_q  <= r_wait_d;
            r_data_q  <= r_data_d;
            r_err_q   <= r_err_d;
        end
    end

    ysyx_23060077_sram_mem #(.IDX_W(DEPTH_LOG2)) u_mem (
        .clk     (aclk),
        .wr_en   (mem_wr_en),
        .wr_idx  (word_idx(w_addr_q)),
        .wr_data (axi_w_data_i),
        .wr_strb (axi_w_strb_i),
        .rd_idx  (word_idx(rd_addr)),
        .rd_data (mem_rd_data)
    );

    assign axi_aw_ready_o = (w_state_q == W_IDLE);
    assign axi_w_ready_o  = (w_state_q == W_DATA);
    assign axi_b_valid_o  = (w_state_q == W_RESP);
    assign axi_b_resp_o   = w_err_q ? RESP_SLVERR : RESP_OKAY;
    assign axi_b_id_o     = w_id_q;

    assign axi_ar_ready_o = (r_state_q == R_IDLE);
    assign axi_r_valid_o  = (r_state_q == R_DATA);
    assign axi_r_data_o   = r_data_q;
    assign axi_r_resp_o   = r_err_q ? RESP_SLVERR : RESP_OKAY;
    assign axi_r_last_o   = (r_state_q == R_DATA) && (r_cnt_q == r_len_q);
    assign axi_r_id_o     = r_id_q;

endmodule

// File: tb/tb_ysyx_23060077_axi_sram.sv
// Scoreboard bench for the AXI SRAM slave: a byte-level reference model
// predicts B and R beats, which are compared as the DUT hands them out.
module tb_ysyx_23060077_axi_sram;

    localparam logic [31:0] BASE   = 32'h8000_0000;
    localparam logic [31:0] LIMIT  = 32'h8000_2000;
    localparam int          RD_LAT = 2;
    localparam int          BOUND  = 60;

    logic        aclk, areset_n;
    logic        aw_valid, aw_ready;
    logic [31:0] aw_addr;
    logic [3:0]  aw_id;
    logic [7:0]  aw_len;
    logic [2:0]  aw_size;
    logic [1:0]  aw_burst;
    logic        w_valid, w_ready, w_last;
    logic [63:0] w_data;
    logic [7:0]  w_strb;
    logic        b_valid, b_ready;
    logic [1:0]  b_resp;
    logic [3:0]  b_id;
    logic        ar_valid, ar_ready;
    logic [31:0] ar_addr;
    logic [3:0]  ar_id;
    logic [7:0]  ar_len;
    logic [2:0]  ar_size;
    logic [1:0]  ar_burst;
    logic        r_valid, r_ready, r_last;
    logic [63:0] r_data;
    logic [1:0]  r_resp;
    logic [3:0]  r_id;

    ysyx_23060077_axi_sram #(
        .BASE_ADDR(BASE), .DEPTH_LOG2(10), .RD_LAT(RD_LAT)
    ) dut (
        .aclk(aclk), .areset_n(areset_n),
        .axi_aw_valid_i(aw_valid), .axi_aw_ready_o(aw_ready), .axi_aw_addr_i(aw_addr),
        .axi_aw_id_i(aw_id), .axi_aw_len_i(aw_len), .axi_aw_size_i(aw_size),
        .axi_aw_burst_i(aw_burst),
        .axi_w_valid_i(w_valid), .axi_w_ready_o(w_ready), .axi_w_data_i(w_data),
        .axi_w_strb_i(w_strb), .axi_w_last_i(w_last),
        .axi_b_valid_o(b_valid), .axi_b_ready_i(b_ready), .axi_b_resp_o(b_resp),
        .axi_b_id_o(b_id),
        .axi_ar_valid_i(ar_valid), .axi_ar_ready_o(ar_ready), .axi_ar_addr_i(ar_addr),
        .axi_ar_id_i(ar_id), .axi_ar_len_i(ar_len), .axi_ar_size_i(ar_size),
        .axi_ar_burst_i(ar_burst),
        .axi_r_valid_o(r_valid), .axi_r_ready_i(r_ready), .axi_r_data_o(r_data),
        .axi_r_resp_o(r_resp), .axi_r_last_o(r_last), .axi_r_id_o(r_id)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    typedef struct {
        logic [63:0] data;
        logic [1:0]  resp;
        logic        last;
        logic [3:0]  id;
    } r_exp_t;

    typedef struct {
        logic [1:0] resp;
        logic [3:0] id;
    } b_exp_t;

    int          checks = 0;
    int          errors = 0;
    r_exp_t      r_exp_q[$];
    b_exp_t      b_exp_q[$];
    logic [63:0] wdata_q[$];
    logic [7:0]  wstrb_q[$];
    logic [63:0] model[int];

    function automatic bit in_range(input logic [31:0] a);
        return (a >= BASE) && (a < LIMIT);
    endfunction

    function automatic int widx(input logic [31:0] a);
        return int'((a - BASE) >> 3);
    endfunction

    task automatic push_read_exp(input logic [31:0] addr, input int len,
                                 input logic [2:0] size, input logic [3:0] id);
        r_exp_t      e;
        logic [31:0] a;
        a = addr;
        for (int i = 0; i <= len; i++) begin
            e.data = in_range(a) ? model[widx(a)] : 64'h0;
            e.resp = in_range(a) ? 2'b00 : 2'b10;
            e.last = (i == len);
            e.id   = id;
            r_exp_q.push_back(e);
            a = a + (32'd1 << size);
        end
    endtask

    task automatic push_beat(input logic [63:0] d, input logic [7:0] s);
        wdata_q.push_back(d);
        wstrb_q.push_back(s);
    endtask

    task automatic axi_write(input logic [31:0] addr, input int len, input logic [2:0] size,
                             input logic [3:0] id, input int w_delay);
        b_exp_t      eb;
        logic [31:0] a;
        logic [63:0] d, m;
        logic [7:0]  s;
        int          n;
        bit          err;
        err = 1'b0;
        @(negedge aclk);
        aw_valid = 1'b1; aw_addr = addr; aw_id = id; aw_len = 8'(len);
        aw_size = size; aw_burst = 2'b00;
        n = 0;
        while (!aw_ready && n < BOUND) begin @(negedge aclk); n++; end
        if (n >= BOUND) begin
            checks++; errors++;
            $display("FAIL aw_timeout: aw_ready stayed %b, required 1", aw_ready);
            aw_valid = 1'b0;
            return;
        end
        @(negedge aclk);
        aw_valid = 1'b0;
        repeat (w_delay) @(negedge aclk);
        a = addr;
        for (int i = 0; i <= len; i++) begin
            d = wdata_q.pop_front();
            s = wstrb_q.pop_front();
            w_valid = 1'b1; w_data = d; w_strb = s; w_last = (i == len);
            n = 0;
            while (!w_ready && n < BOUND) begin @(negedge aclk); n++; end
            if (n >= BOUND) begin
                checks++; errors++;
                $display("FAIL w_timeout: w_ready stayed %b on beat %0d, required 1", w_ready, i);
                w_valid = 1'b0;
                return;
            end
            @(negedge aclk);
            if (in_range(a)) begin
                m = model.exists(widx(a)) ? model[widx(a)] : 64'h0;
                for (int b = 0; b < 8; b++) if (s[b]) m[b*8 +: 8] = d[b*8 +: 8];
                model[widx(a)] = m;
            end else begin
                err = 1'b1;
            end
            a = a + (32'd1 << size);
        end
        w_valid = 1'b0; w_last = 1'b0;
        eb.resp = err ? 2'b10 : 2'b00;
        eb.id   = id;
        b_exp_q.push_back(eb);
        b_ready = 1'b1;
        n = 0;
        while (!b_valid && n < BOUND) begin @(negedge aclk); n++; end
        if (n >= BOUND) begin
            checks++; errors++;
            $display("FAIL b_timeout: b_valid stayed %b, required 1", b_valid);
            b_ready = 1'b0;
            return;
        end
        eb = b_exp_q.pop_front();
        checks++;
        if (b_resp !== eb.resp || b_id !== eb.id) begin
            errors++;
            $display("FAIL b_resp @%h: got resp=%b id=%h, required resp=%b id=%h",
                     addr, b_resp, b_id, eb.resp, eb.id);
        end
        @(negedge aclk);
        b_ready = 1'b0;
    endtask

    // pat[k] is r_ready on the k-th cycle after r_valid first rises.
    task automatic axi_read(input logic [31:0] addr, input int len, input logic [2:0] size,
                            input logic [3:0] id, input logic [15:0] pat,
                            output int lat, output int data_cycles);
        r_exp_t      e;
        logic [70:0] held;
        bit          stalled;
        int          n, k, beats;
        lat = 0; data_cycles = 0;
        @(negedge aclk);
        ar_valid = 1'b1; ar_addr = addr; ar_id = id; ar_len = 8'(len);
        ar_size = size; ar_burst = 2'b01;
        n = 0;
        while (!ar_ready && n < BOUND) begin @(negedge aclk); n++; end
        if (n >= BOUND) begin
            checks++; errors++;
            $display("FAIL ar_timeout: ar_ready stayed %b, required 1", ar_ready);
            ar_valid = 1'b0;
            return;
        end
        @(negedge aclk);
        ar_valid = 1'b0;
        n = 0;
        while (!r_valid && n < BOUND) begin @(negedge aclk); lat++; n++; end
        if (n >= BOUND) begin
            checks++; errors++;
            $display("FAIL r_timeout: r_valid stayed %b, required 1", r_valid);
            return;
        end
        k = 0; beats = 0; stalled = 1'b0; held = '0;
        while (beats <= len && k < 4 * BOUND) begin
            r_ready = (k < 16) ? pat[k] : 1'b1;
            if (r_valid) begin
                if (stalled) begin
                    checks++;
                    if ({r_data, r_resp, r_last, r_id} !== held) begin
                        errors++;
                        $display("FAIL r_stall_stable: got %h, required %h",
                                 {r_data, r_resp, r_last, r_id}, held);
                    end
                end
                if (r_ready) begin
                    checks++;
                    if (r_exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL r_unexpected: got data=%h, required no beat", r_data);
                    end else begin
                        e = r_exp_q.pop_front();
                        if (r_data !== e.data || r_resp !== e.resp ||
                            r_last !== e.last || r_id !== e.id) begin
                            errors++;
                            $display("FAIL r_beat @%h #%0d: got data=%h resp=%b last=%b id=%h, required data=%h resp=%b last=%b id=%h",
                                     addr, beats, r_data, r_resp, r_last, r_id,
                                     e.data, e.resp, e.last, e.id);
                        end
                    end
                    beats++;
                    stalled = 1'b0;
                end else begin
                    held    = {r_data, r_resp, r_last, r_id};
                    stalled = 1'b1;
                end
            end
            @(negedge aclk);
            k++;
            data_cycles++;
        end
        r_ready = 1'b0;
        if (beats <= len) begin
            checks++; errors++;
            $display("FAIL r_burst_timeout: got %0d beats, required %0d", beats, len + 1);
        end
    endtask

    task automatic test_reset();
        logic [83:0] got;
        areset_n = 1'b1;
        #1 areset_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            #7;
            got = {aw_ready, w_ready, b_valid, b_resp, b_id, ar_ready,
                   r_valid, r_data, r_resp, r_last, r_id};
            checks++;
            if (got !== {1'b1, 1'b0, 1'b0, 2'b00, 4'h0, 1'b1, 1'b0, 64'h0, 2'b00, 1'b0, 4'h0}) begin
                errors++;
                $display("FAIL reset_outputs[%0d]: got %h, required %h", i, got,
                         {1'b1, 1'b0, 1'b0, 2'b00, 4'h0, 1'b1, 1'b0, 64'h0, 2'b00, 1'b0, 4'h0});
            end
        end
        @(negedge aclk);
        areset_n = 1'b1;
    endtask

    task automatic test_single();
        int lat, dc;
        push_beat(64'h1122334455667788, 8'hFF);
        axi_write(32'h8000_0010, 0, 3'd3, 4'h5, 0);
        push_read_exp(32'h8000_0010, 0, 3'd3, 4'h6);
        axi_read(32'h8000_0010, 0, 3'd3, 4'h6, 16'hFFFF, lat, dc);
        checks++;
        if (lat !== RD_LAT) begin
            errors++;
            $display("FAIL single_latency: got %0d, required %0d", lat, RD_LAT);
        end
    endtask

    task automatic test_incr_strb();
        int lat, dc;
        for (int i = 0; i < 4; i++) push_beat(64'hA0A0_A0A0_0000_0000 | 64'(i * 32'h0101_0101), 8'hFF);
        axi_write(BASE, 3, 3'd3, 4'h1, 0);
        for (int i = 0; i < 4; i++) push_beat(64'hB5B5_B5B5_B5B5_B500 | 64'(i), (i == 2) ? 8'h0F : 8'hFF);
        axi_write(BASE, 3, 3'd3, 4'h2, 0);
        push_read_exp(BASE, 3, 3'd3, 4'hA);
        axi_read(BASE, 3, 3'd3, 4'hA, 16'hFFFF, lat, dc);
        checks++;
        if (dc !== 4) begin
            errors++;
            $display("FAIL back_to_back: got %0d data cycles, required 4", dc);
        end
    endtask

    task automatic test_stall_latency();
        int lat, dc;
        push_read_exp(BASE + 32'h8, 1, 3'd3, 4'h7);
        axi_read(BASE + 32'h8, 1, 3'd3, 4'h7, 16'hFFF9, lat, dc);
        checks++;
        if (lat !== RD_LAT || dc !== 4) begin
            errors++;
            $display("FAIL stall_latency: got lat=%0d cycles=%0d, required lat=%0d cycles=4",
                     lat, dc, RD_LAT);
        end
    endtask

    task automatic test_slverr();
        int lat, dc;
        push_beat(64'hC0FF_EE00_1234_5678, 8'hFF);
        axi_write(32'h8000_1FF8, 0, 3'd3, 4'h3, 0);
        push_beat(64'hDEAD_BEEF_DEAD_BEEF, 8'hFF);
        axi_write(32'h7FFF_FFF8, 0, 3'd3, 4'h4, 0);
        push_read_exp(32'h8000_1FF8, 0, 3'd3, 4'h3);
        axi_read(32'h8000_1FF8, 0, 3'd3, 4'h3, 16'hFFFF, lat, dc);
        push_read_exp(32'h7FFF_FFF8, 0, 3'd3, 4'h4);
        axi_read(32'h7FFF_FFF8, 0, 3'd3, 4'h4, 16'hFFFF, lat, dc);
        push_beat(64'h0F0F_0F0F_F0F0_F0F0, 8'hFF);
        push_beat(64'h5555_5555_5555_5555, 8'hFF);
        axi_write(32'h8000_1FF8, 1, 3'd3, 4'hC, 0);
        push_read_exp(32'h8000_1FF8, 1, 3'd3, 4'hD);
        axi_read(32'h8000_1FF8, 1, 3'd3, 4'hD, 16'hFFFF, lat, dc);
    endtask

    task automatic test_same_cycle();
        int lat, dc;
        push_beat(64'h0101_0101_0101_0101, 8'hFF);
        axi_write(32'h8000_0100, 0, 3'd3, 4'h8, 0);
        push_read_exp(32'h8000_0100, 0, 3'd3, 4'h9);
        push_beat(64'h2222_3333_4444_5555, 8'hFF);
        fork
            axi_write(32'h8000_0100, 0, 3'd3, 4'h8, 1);
            axi_read(32'h8000_0100, 0, 3'd3, 4'h9, 16'hFFFF, lat, dc);
        join
        push_read_exp(32'h8000_0100, 0, 3'd3, 4'hB);
        axi_read(32'h8000_0100, 0, 3'd3, 4'hB, 16'hFFFF, lat, dc);
    endtask

    task automatic test_reset_midburst();
        int lat, dc, n;
        @(negedge aclk);
        ar_valid = 1'b1; ar_addr = BASE; ar_id = 4'hE; ar_len = 8'd7; ar_size = 3'd3;
        n = 0;
        while (!ar_ready && n < BOUND) begin @(negedge aclk); n++; end
        @(negedge aclk);
        ar_valid = 1'b0;
        r_ready  = 1'b1;
        n = 0;
        while (!r_valid && n < BOUND) begin @(negedge aclk); n++; end
        repeat (2) @(negedge aclk);
        checks++;
        if (r_valid !== 1'b1) begin
            errors++;
            $display("FAIL midburst_valid: got r_valid=%b, required 1", r_valid);
        end
        #2 areset_n = 1'b0;
        #1;
        checks++;
        if ({r_valid, r_last, r_data, r_resp, r_id, ar_ready} !== {1'b0, 1'b0, 64'h0, 2'b00, 4'h0, 1'b1}) begin
            errors++;
            $display("FAIL async_reset: got valid=%b last=%b data=%h resp=%b id=%h ar_ready=%b, required 0 0 0 0 0 1",
                     r_valid, r_last, r_data, r_resp, r_id, ar_ready);
        end
        @(negedge aclk);
        areset_n = 1'b1;
        r_ready  = 1'b0;
        push_read_exp(BASE, 1, 3'd3, 4'h3);
        axi_read(BASE, 1, 3'd3, 4'h3, 16'hFFFF, lat, dc);
    endtask

    initial begin
        aw_valid = 0; aw_addr = 0; aw_id = 0; aw_len = 0; aw_size = 3; aw_burst = 0;
        w_valid = 0; w_data = 0; w_strb = 0; w_last = 0; b_ready = 0;
        ar_valid = 0; ar_addr = 0; ar_id = 0; ar_len = 0; ar_size = 3; ar_burst = 0;
        r_ready = 0;
        test_reset();
        test_single();
        test_incr_strb();
        test_stall_latency();
        test_slverr();
        test_same_cycle();
        test_reset_midburst();
        checks++;
        if (r_exp_q.size() != 0 || b_exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d R and %0d B left, required 0 and 0",
                     r_exp_q.size(), b_exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
